branch_predict_ctrl: RTL
========================

Name: branch_predict_ctrl

Overview:
- Sequences fetch-side branch handling for the RISC-V core.
- A table of 2-bit saturating counters (BHT) predicts branch direction at fetch. At execute, the resolved outcome (the branch unit's pc_sel) updates the table.
- On a misprediction, the block issues one redirect and holds the front-end flush for a fixed number of cycles.
- It also keeps saturating branch and mispredict statistics counters.

Parameters:
- IDX_W, 6, BHT index width; table holds 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a mispredict (>=1).
- XLEN, 32, PC and statistics counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  XLEN  PC of the instruction being fetched
- predict_taken  out  1  combinational: MSB of BHT[fetch_pc index]
- resolve_valid  in  1  a conditional branch resolves this cycle in EX
- resolve_pc  in  XLEN  PC of the resolving branch
- resolve_taken  in  1  actual outcome (pc_sel from branch unit)
- resolve_pred  in  1  prediction carried down the pipe with the branch
- resolve_target  in  XLEN  computed branch target
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
- redirect_pc  out  XLEN  correct next PC
- flush  out  1  kill IF/ID contents
- branch_count  out  XLEN  accepted resolves, saturating
- mispredict_count  out  XLEN  mispredicts, saturating

Behaviour:
- Reset (async, any time, including mid-flush):
  - All BHT entries = 2'b01 (weakly not-taken); FSM = IDLE.
  - redirect_valid = 0, redirect_pc = 0, flush = 0, both statistics counters = 0, internal flush counter = 0.
- Lookup:
  - predict_taken = BHT[idx][1], where idx = fetch_pc[IDX_W+1:2]. Purely combinational; no bypass.
  - When a same-cycle update targets the same index, the lookup returns the pre-update value.
- Accepted resolve: resolve_valid=1 while FSM=IDLE. Resolves arriving in FLUSH are wrong-path and ignored entirely: no BHT update, no statistics change.
- BHT update on an accepted resolve, written at the clock edge:
  - taken: counter += 1, saturating at 2'b11.
  - not taken: counter -= 1, saturating at 2'b00.
  - Only the entry at resolve_pc's index changes.
- Mispredict = accepted resolve with resolve_taken != resolve_pred.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on mispredict. At that edge, register:
    - redirect_pc = resolve_taken ? resolve_target : resolve_pc + 4 (mod 2^XLEN; wrap allowed).
    - redirect_valid = 1.
    - flush counter = FLUSH_CYCLES-1.
  - In FLUSH:
    - flush = 1.
    - redirect_valid = 1 only in the first FLUSH cycle.
    - The counter decrements each cycle; at 0 the FSM returns to IDLE on the next edge.
  - Net effect: flush is high for exactly FLUSH_CYCLES cycles, starting the cycle after the resolve.
  - redirect_pc holds its value until the next mispredict.
- Correct prediction: no redirect, no flush, FSM stays IDLE.
- Statistics:
  - branch_count += 1 per accepted resolve.
  - mispredict_count += 1 per mispredict.
  - Both saturate at 2^XLEN-1 and never wrap.
- Back-to-back: a mispredict in the cycle immediately after FLUSH ends (FSM in IDLE) is accepted normally.

Test Plan:
- Reset, then fetch_pc=0x100 -> predict_taken=0. Assert rst mid-FLUSH -> flush=0, redirect_valid=0 immediately (asynchronous).
- Resolve pc=0x100 taken, pred=0, target=0x80 -> next cycle: redirect_valid=1, redirect_pc=0x80, flush=1 for 2 cycles; branch_count=1, mispredict_count=1; predict_taken at 0x100 becomes 1.
- Resolve pc=0x200 not-taken, pred=1 -> redirect_pc=0x204. Also: pc=0xFFFFFFFC not-taken, pred=1 -> redirect_pc=0x0 (wrap).
- Four taken resolves at pc=0x40 with matching preds -> counter saturates at 11, no flush. Then one not-taken (pred=1) -> counter=10, predict_taken remains 1, mispredict_count increments.
- resolve_valid=1 with a mismatch during both FLUSH cycles -> ignored: counts unchanged, BHT unchanged, no second redirect. Mispredict one cycle after FLUSH ends -> new redirect.
- Same-cycle update and lookup at index 5 (counter 01, taken) -> predict_taken=0 that cycle, 1 the next. With mispredict_count forced to 0xFFFFFFFF, a further mispredict leaves it at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch handling: a table of 2-bit saturating counters predicts
// direction at fetch, resolved branches update it at execute, and a mispredict
// produces a single redirect pulse followed by a fixed-length front-end flush.
// Saturating statistics count accepted resolves and mispredicts.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   fetch_pc          PC being fetched; predict_taken is the lookup result (comb)
//   resolve_*         branch resolution from EX (valid, pc, taken, pred, target)
//   redirect_valid    one-cycle pulse telling fetch to load redirect_pc
//   redirect_pc       correct next PC, held until the next mispredict
//   flush             kill IF/ID contents
//   branch_count      accepted resolves (saturating)
//   mispredict_count  mispredicts (saturating)
module branch_predict_ctrl #(
  parameter int unsigned IDX_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  input  logic            resolve_valid,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic            resolve_taken,
  input  logic            resolve_pred,
  input  logic [XLEN-1:0] resolve_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [XLEN-1:0] branch_count,
  output logic [XLEN-1:0] mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e            state_q, state_d;
  logic [1:0]        bht_q [Entries];
  logic [1:0]        bht_d [Entries];
  logic [CntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   branch_count_q, branch_count_d;
  logic [XLEN-1:0]   mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0]  fetch_idx;
  logic [IDX_W-1:0]  resolve_idx;
  logic              accept;
  logic              mispredict;
  logic [1:0]        ctr_old;
  logic [1:0]        ctr_new;

  assign fetch_idx   = fetch_pc[IDX_W+1:2];
  assign resolve_idx = resolve_pc[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign predict_taken = bht_q[fetch_idx][1];

  // Resolves seen while flushing belong to the wrong path and are dropped.
  assign accept     = resolve_valid && (state_q == StIdle);
  assign mispredict = accept && (resolve_taken != resolve_pred);

  always_comb begin
    ctr_old = bht_q[resolve_idx];
    ctr_new = ctr_old;
    if (resolve_taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (accept) bht_d[resolve_idx] = ctr_new;
  end

  always_comb begin
    state_d            = state_q;
    flush_cnt_d        = flush_cnt_q;
    redirect_valid_d   = 1'b0;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;

    if (accept && (branch_count_q != {XLEN{1'b1}})) begin
      branch_count_d = branch_count_q + 1'b1;
    end
    if (mispredict && (mispredict_count_q != {XLEN{1'b1}})) begin
      mispredict_count_d = mispredict_count_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (mispredict) begin
          state_d          = StFlush;
          flush_cnt_d      = CntW'(FLUSH_CYCLES - 1);
          redirect_valid_d = 1'b1;
          redirect_pc_d    = resolve_taken ? resolve_target : resolve_pc + XLEN'(4);
        end
      end
      StFlush: begin
        if (flush_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    flush_d = (state_d == StFlush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= StIdle;
      flush_cnt_q        <= '0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      flush_q            <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < Entries; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q            <= state_d;
      flush_cnt_q        <= flush_cnt_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      flush_q            <= flush_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      bht_q              <= bht_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign flush            = flush_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
